hyper_rx_packer: RTL and testbench

//  Downstream of the HyperBus PHY RX path, upstream of the uDMA linear RX channel.

---
 rtl/hyper_pkg.sv | 16 +
 rtl/udma_pkg.sv | 11 +
 rtl/hyper_rx_packer.sv | 151 +++++++++++++++
 tb/tb_hyper_rx_packer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_pkg.sv
// HyperBus RX beat format and the packer's transfer state encoding.
package hyper_pkg;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  be;
        logic        last;
    } hyper_rx_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } packer_state_e;

endpackage

// File: rtl/udma_pkg.sv
// Shared uDMA constants: transfer counter width and the datasize encoding
// used on the linear RX channel.
package udma_pkg;

    localparam int TRANS_SIZE = 20;

    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

endpackage

// File: rtl/hyper_rx_packer.sv
// Packs 16-bit HyperBus read beats (with byte enables) into little-endian
// 32-bit uDMA writes, flushing residual bytes as halfword/byte at end of transfer.
module hyper_rx_packer #(
    parameter int TRANS_SIZE = udma_pkg::TRANS_SIZE,
    parameter bit SWAP_BYTES = 1'b0
) (
    input  logic                  sys_clk_i,
    input  logic                  rstn_i,
    input  logic                  clr_i,
    input  logic [15:0]           in_data_i,
    input  logic [1:0]            in_be_i,
    input  logic                  in_last_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [31:0]           out_data_o,
    output logic [1:0]            out_datasize_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [TRANS_SIZE-1:0] rx_bytes_o,
    output logic                  eot_o
);
    import hyper_pkg::*;

    // Byte lane k of the accumulator is acc[8k+7:8k]; lanes at or above cnt are kept zero.
    logic [47:0]           acc_q, acc_d;
    logic [2:0]            cnt_q, cnt_d;
    packer_state_e         state_q, state_d;
    logic [TRANS_SIZE-1:0] rx_bytes_q, rx_bytes_d;
    logic                  eot_q, eot_d;

    hyper_rx_beat_t beat;
    logic           flushing;
    logic           push, pop;
    logic [2:0]     size_n;
    logic [2:0]     pop_n, push_n, base;
    logic [7:0]     byte_lo, byte_hi;
    logic [15:0]    new_bytes;

    assign beat     = '{data: in_data_i, be: in_be_i, last: in_last_i};
    assign flushing = (state_q == ST_FLUSH);

    // Size of the write currently presented; zero means nothing is offered.
    always_comb begin
        size_n = 3'd0;
        if (flushing) begin
            if (cnt_q >= 3'd4)      size_n = 3'd4;
            else if (cnt_q >= 3'd2) size_n = 3'd2;
            else if (cnt_q == 3'd1) size_n = 3'd1;
        end else if (cnt_q >= 3'd4) begin
            size_n = 3'd4;
        end
    end

    assign in_ready_o  = !flushing && (cnt_q <= 3'd4);
    assign out_valid_o = (size_n != 3'd0);

    always_comb begin
        out_data_o     = 32'h0;
        out_datasize_o = udma_pkg::DS_WORD;
        case (size_n)
            3'd4: out_data_o = acc_q[31:0];
            3'd2: begin
                out_data_o     = {16'h0, acc_q[15:0]};
                out_datasize_o = udma_pkg::DS_HALF;
            end
            3'd1: begin
                out_data_o     = {24'h0, acc_q[7:0]};
                out_datasize_o = udma_pkg::DS_BYTE;
            end
            default: ;
        endcase
    end

    assign rx_bytes_o = rx_bytes_q;
    assign eot_o      = eot_q;

    assign byte_lo = SWAP_BYTES ? beat.data[15:8] : beat.data[7:0];
    assign byte_hi = SWAP_BYTES ? beat.data[7:0]  : beat.data[15:8];

    // Shift out the popped bytes and append the pushed ones in a single step,
    // so a simultaneous pop and push neither loses nor duplicates data.
    always_comb begin
        push   = in_valid_i && in_ready_o;
        pop    = out_valid_o && out_ready_i;
        pop_n  = pop ? size_n : 3'd0;
        push_n = push ? ({2'b00, beat.be[0]} + {2'b00, beat.be[1]}) : 3'd0;
        base   = cnt_q - pop_n;

        new_bytes = 16'h0;
        case (beat.be)
            2'b01:   new_bytes = {8'h00, byte_lo};
            2'b10:   new_bytes = {8'h00, byte_hi};
            2'b11:   new_bytes = {byte_hi, byte_lo};
            default: new_bytes = 16'h0;
        endcase

        acc_d = acc_q >> {pop_n, 3'b000};
        if (push) begin
            acc_d = acc_d | ({32'h0, new_bytes} << {base, 3'b000});
        end
        cnt_d      = cnt_q - pop_n + push_n;
        rx_bytes_d = rx_bytes_q + TRANS_SIZE'(pop_n);

        state_d = state_q;
        eot_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (push) begin
                    if (!beat.last) begin
                        state_d = ST_RUN;
                    end else if (cnt_d == 3'd0) begin
                        state_d = ST_IDLE;
                        eot_d   = 1'b1;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_d == 3'd0) begin
                    state_d = ST_IDLE;
                    eot_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            rx_bytes_q <= '0;
            eot_q      <= 1'b0;
        end else if (clr_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            rx_bytes_q <= '0;
            eot_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            rx_bytes_q <= rx_bytes_d;
            eot_q      <= eot_d;
        end
    end

endmodule

// File: tb/tb_hyper_rx_packer.sv
// Randomised and directed bench for hyper_rx_packer against a byte-queue
// reference model of the packing and flush rules.
module tb_hyper_rx_packer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] in_data = '0;
    logic [1:0]  in_be = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, eot;
    logic [31:0] out_data;
    logic [1:0]  out_ds;
    logic [19:0] rx_bytes;

    logic        sw_in_ready, sw_out_valid, sw_eot;
    logic [31:0] sw_out_data;
    logic [1:0]  sw_out_ds;
    logic [19:0] sw_rx_bytes;

    int checks = 0;
    int errors = 0;
    int rdy_low_pct = 0;

    always #5 clk = ~clk;

    hyper_rx_packer #(.TRANS_SIZE(20), .SWAP_BYTES(1'b0)) dut (
        .sys_clk_i(clk), .rstn_i(rstn), .clr_i(clr),
        .in_data_i(in_data), .in_be_i(in_be), .in_last_i(in_last),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_datasize_o(out_ds), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .rx_bytes_o(rx_bytes), .eot_o(eot)
    );

    hyper_rx_packer #(.TRANS_SIZE(20), .SWAP_BYTES(1'b1)) dut_sw (
        .sys_clk_i(clk), .rstn_i(rstn), .clr_i(clr),
        .in_data_i(in_data), .in_be_i(in_be), .in_last_i(in_last),
        .in_valid_i(in_valid), .in_ready_o(sw_in_ready),
        .out_data_o(sw_out_data), .out_datasize_o(sw_out_ds), .out_valid_o(sw_out_valid),
        .out_ready_i(out_ready), .rx_bytes_o(sw_rx_bytes), .eot_o(sw_eot)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending bytes in arrival order, end-of-transfer flag, emitted total.
    logic [7:0]  mq[$];
    logic        mflush = 1'b0;
    logic [19:0] mrx = '0;
    logic        eot_exp = 1'b0;
    int          eot_cnt = 0;
    logic        hold = 1'b0;
    logic [31:0] held_data;
    logic [1:0]  held_ds;
    logic [33:0] wlog[$];
    logic [33:0] swlog[$];

    always @(negedge clk) begin
        int          n_exp;
        logic [31:0] exp_data;
        logic [1:0]  exp_ds;
        if (!rstn) begin
            mq.delete(); mflush = 1'b0; mrx = '0; eot_exp = 1'b0; hold = 1'b0;
        end else begin
            if (mflush) n_exp = (mq.size() >= 4) ? 4 : (mq.size() >= 2) ? 2 : mq.size();
            else        n_exp = (mq.size() >= 4) ? 4 : 0;
            check("valid", {31'b0, out_valid}, {31'b0, (n_exp != 0)});
            check("in_ready", {31'b0, in_ready}, {31'b0, (!mflush && mq.size() <= 4)});
            check("rx_bytes", {12'b0, rx_bytes}, {12'b0, mrx});
            check("eot", {31'b0, eot}, {31'b0, eot_exp});
            if (eot) eot_cnt++;
            if (hold) begin
                check("stall_data", out_data, held_data);
                check("stall_ds", {30'b0, out_ds}, {30'b0, held_ds});
            end
            if (out_valid && n_exp != 0) begin
                exp_data = '0;
                for (int i = 0; i < n_exp; i++) exp_data[8*i +: 8] = mq[i];
                exp_ds = (n_exp == 4) ? 2'b10 : (n_exp == 2) ? 2'b01 : 2'b00;
                check("word_data", out_data, exp_data);
                check("word_ds", {30'b0, out_ds}, {30'b0, exp_ds});
            end
            if (clr) begin
                mq.delete(); mflush = 1'b0; mrx = '0; eot_exp = 1'b0; hold = 1'b0;
                eot_cnt = 0; wlog.delete(); swlog.delete();
            end else begin
                hold      = out_valid && !out_ready;
                held_data = out_data;
                held_ds   = out_ds;
                if (out_valid && out_ready) wlog.push_back({out_ds, out_data});
                if (sw_out_valid && out_ready) swlog.push_back({sw_out_ds, sw_out_data});
                if (out_valid && out_ready && n_exp != 0) begin
                    for (int i = 0; i < n_exp; i++) void'(mq.pop_front());
                    mrx = mrx + 20'(n_exp);
                end
                if (in_valid && in_ready) begin
                    if (in_be[0]) mq.push_back(in_data[7:0]);
                    if (in_be[1]) mq.push_back(in_data[15:8]);
                    if (in_last) mflush = 1'b1;
                end
                eot_exp = 1'b0;
                if (mflush && mq.size() == 0) begin
                    eot_exp = 1'b1;
                    mflush  = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 99) >= rdy_low_pct);
        end
    end

    task automatic send_beat(input logic [15:0] d, input logic [1:0] be, input logic last);
        logic acc;
        acc = 1'b0;
        in_data = d; in_be = be; in_last = last; in_valid = 1'b1;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_eot();
        for (int k = 0; k < 200 && eot_cnt == 0; k++) @(posedge clk);
        #1;
        if (eot_cnt == 0) check("eot_timeout", 32'd0, 32'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_ds", {30'b0, out_ds}, 32'd2);
        check("rst_rx_bytes", {12'b0, rx_bytes}, 32'd0);
        check("rst_eot", {31'b0, eot}, 32'd0);
        @(posedge clk);
        #1;

        // Full-word transfer
        rdy_low_pct = 0;
        pulse_clr();
        send_beat(16'h1100, 2'b11, 1'b0);
        send_beat(16'h3322, 2'b11, 1'b0);
        send_beat(16'h5544, 2'b11, 1'b0);
        send_beat(16'h7766, 2'b11, 1'b1);
        wait_eot();
        check("t1_nwords", wlog.size(), 32'd2);
        if (wlog.size() >= 2) begin
            check("t1_w0", wlog[0][31:0], 32'h33221100);
            check("t1_ds0", {30'b0, wlog[0][33:32]}, 32'd2);
            check("t1_w1", wlog[1][31:0], 32'h77665544);
        end
        check("t1_rx_bytes", {12'b0, rx_bytes}, 32'd8);
        check("t1_eot_cnt", eot_cnt, 32'd1);

        // 7 bytes: word, halfword, byte
        pulse_clr();
        send_beat(16'h0100, 2'b11, 1'b0);
        send_beat(16'h0302, 2'b11, 1'b0);
        send_beat(16'h0504, 2'b11, 1'b0);
        send_beat(16'hEE06, 2'b01, 1'b1);
        wait_eot();
        check("t2_nwords", wlog.size(), 32'd3);
        if (wlog.size() >= 3) begin
            check("t2_w0", {wlog[0][33:32], wlog[0][31:0]} , {2'b10, 32'h03020100});
            check("t2_h1", {wlog[1][33:32], wlog[1][31:0]} , {2'b01, 32'h00000504});
            check("t2_b2", {wlog[2][33:32], wlog[2][31:0]} , {2'b00, 32'h00000006});
        end
        check("t2_rx_bytes", {12'b0, rx_bytes}, 32'd7);
        check("t2_eot_cnt", eot_cnt, 32'd1);

        // Empty transfer
        pulse_clr();
        send_beat(16'h1234, 2'b00, 1'b1);
        wait_eot();
        check("t4_nwords", wlog.size(), 32'd0);
        check("t4_eot_cnt", eot_cnt, 32'd1);
        check("t4_rx_bytes", {12'b0, rx_bytes}, 32'd0);

        // Clear during flush with 3 residual bytes
        rdy_low_pct = 100;
        @(posedge clk);
        #1;
        pulse_clr();
        send_beat(16'h2211, 2'b11, 1'b0);
        send_beat(16'h0033, 2'b01, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t5_pre_valid", {31'b0, out_valid}, 32'd1);
        check("t5_pre_ds", {30'b0, out_ds}, 32'd1);
        @(posedge clk);
        #1;
        pulse_clr();
        @(negedge clk);
        check("t5_valid", {31'b0, out_valid}, 32'd0);
        check("t5_rx_bytes", {12'b0, rx_bytes}, 32'd0);
        check("t5_in_ready", {31'b0, in_ready}, 32'd1);
        rdy_low_pct = 0;
        repeat (8) @(posedge clk);
        #1;
        check("t5_no_eot", eot_cnt, 32'd0);

        // Byte swap instance
        pulse_clr();
        send_beat(16'hAABB, 2'b11, 1'b0);
        send_beat(16'hAABB, 2'b11, 1'b1);
        wait_eot();
        check("t6_sw_nwords", swlog.size(), 32'd1);
        if (swlog.size() >= 1) check("t6_sw_word", swlog[0][31:0], 32'hBBAABBAA);
        if (wlog.size() >= 1) check("t6_word", wlog[0][31:0], 32'hAABBAABB);
        check("t6_sw_rx_bytes", {12'b0, sw_rx_bytes}, 32'd4);

        // Random stream with output stalls
        rdy_low_pct = 30;
        pulse_clr();
        for (int b = 0; b < 1000; b++) begin
            send_beat(16'($urandom), 2'($urandom), (b == 999) || ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (60) @(posedge clk);
        #1;
        check("t3_drained", mq.size(), 32'd0);
        check("t3_valid_idle", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=0 expected=1");
        $fatal(1, "timeout");
    end

endmodule
